lcd_timing_gen: RTL and testbench

Generates the RGB666 panel timing from the free-running on-chip oscillator clock. It produces a divided pixel clock (`lcd_dclk`), a per-pixel strobe (`pix_ce`), `hsync`, `vsync` and `de`, and the current pixel coordinates. It sits directly downstream of the oscillator wrapper and upstream of the pixel-data (pattern/framebuffer) stage, which presents RGB data on cycles where `pix_ce`=1.

---
 rtl/lcd_timing_pkg.sv | 44 ++++
 rtl/lcd_timing_gen.sv | 150 +++++++++++++++
 tb/tb_lcd_timing_gen.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/lcd_timing_pkg.sv
// Shared panel timing constants, per-axis timing configuration and coordinate type
// for the RGB666 LCD timing generator.
package lcd_timing_pkg;

    localparam int unsigned COORD_W = 12;

    typedef logic [COORD_W-1:0] coord_t;

    // Default 800x480 panel timing
    localparam int unsigned DEF_PCLK_DIV = 2;
    localparam int unsigned DEF_H_ACTIVE = 800;
    localparam int unsigned DEF_H_FP     = 210;
    localparam int unsigned DEF_H_SYNC   = 20;
    localparam int unsigned DEF_H_BP     = 26;
    localparam int unsigned DEF_V_ACTIVE = 480;
    localparam int unsigned DEF_V_FP     = 22;
    localparam int unsigned DEF_V_SYNC   = 10;
    localparam int unsigned DEF_V_BP     = 13;

    typedef struct packed {
        coord_t active;
        coord_t fp;
        coord_t sync;
        coord_t bp;
    } timing_cfg_t;

    typedef enum logic {
        StIdle,
        StRun
    } run_state_e;

    function automatic int unsigned cfg_total(input timing_cfg_t cfg);
        return int'(cfg.active) + int'(cfg.fp) + int'(cfg.sync) + int'(cfg.bp);
    endfunction

    function automatic int unsigned cfg_sync_start(input timing_cfg_t cfg);
        return int'(cfg.active) + int'(cfg.fp);
    endfunction

    function automatic int unsigned cfg_sync_end(input timing_cfg_t cfg);
        return int'(cfg.active) + int'(cfg.fp) + int'(cfg.sync);
    endfunction

endpackage

// File: rtl/lcd_timing_gen.sv
// LCD panel timing generator: divides the oscillator clock into a pixel clock and
// produces registered hsync/vsync/de, pixel strobe and coordinates.
module lcd_timing_gen
    import lcd_timing_pkg::*;
#(
    parameter int unsigned PCLK_DIV = DEF_PCLK_DIV,
    parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
    parameter int unsigned H_FP     = DEF_H_FP,
    parameter int unsigned H_SYNC   = DEF_H_SYNC,
    parameter int unsigned H_BP     = DEF_H_BP,
    parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
    parameter int unsigned V_FP     = DEF_V_FP,
    parameter int unsigned V_SYNC   = DEF_V_SYNC,
    parameter int unsigned V_BP     = DEF_V_BP,
    parameter logic        HS_POL   = 1'b0,
    parameter logic        VS_POL   = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    output logic        lcd_dclk,
    output logic        pix_ce,
    output logic        hsync,
    output logic        vsync,
    output logic        de,
    output logic [11:0] x,
    output logic [11:0] y,
    output logic        frame_start
);

    localparam timing_cfg_t H_CFG = '{
        active: coord_t'(H_ACTIVE), fp: coord_t'(H_FP), sync: coord_t'(H_SYNC), bp: coord_t'(H_BP)
    };
    localparam timing_cfg_t V_CFG = '{
        active: coord_t'(V_ACTIVE), fp: coord_t'(V_FP), sync: coord_t'(V_SYNC), bp: coord_t'(V_BP)
    };

    localparam coord_t H_LAST    = coord_t'(cfg_total(H_CFG) - 1);
    localparam coord_t V_LAST    = coord_t'(cfg_total(V_CFG) - 1);
    localparam coord_t H_SYNC_LO = coord_t'(cfg_sync_start(H_CFG));
    localparam coord_t H_SYNC_HI = coord_t'(cfg_sync_end(H_CFG));
    localparam coord_t V_SYNC_LO = coord_t'(cfg_sync_start(V_CFG));
    localparam coord_t V_SYNC_HI = coord_t'(cfg_sync_end(V_CFG));

    localparam int unsigned PH_W = (PCLK_DIV > 2) ? $clog2(PCLK_DIV) : 1;
    localparam logic [PH_W-1:0] PH_LAST = PH_W'(PCLK_DIV - 1);
    localparam logic [PH_W-1:0] PH_HALF = PH_W'(PCLK_DIV / 2);

    run_state_e      r_state;
    run_state_e      w_state_next;
    logic [PH_W-1:0] r_ph;
    logic [PH_W-1:0] w_ph_next;
    coord_t          r_h;
    coord_t          w_h_next;
    coord_t          r_v;
    coord_t          w_v_next;

    logic   r_dclk, r_pix_ce, r_hsync, r_vsync, r_de, r_frame_start;
    coord_t r_x, r_y;

    logic   w_run;
    logic   w_dclk_next, w_pix_ce_next, w_hsync_next, w_vsync_next, w_de_next;
    logic   w_frame_start_next;
    logic   w_hs_window, w_vs_window;

    // Leaving idle lands on (0,0) with ph=0 so the first running cycle is a pixel strobe.
    always_comb begin
        w_state_next = StIdle;
        w_ph_next    = '0;
        w_h_next     = '0;
        w_v_next     = '0;
        if (en) begin
            w_state_next = StRun;
            if (r_state == StRun) begin
                w_h_next = r_h;
                w_v_next = r_v;
                if (r_ph == PH_LAST) begin
                    w_ph_next = '0;
                    if (r_h == H_LAST) begin
                        w_h_next = '0;
                        w_v_next = (r_v == V_LAST) ? '0 : r_v + 12'd1;
                    end else begin
                        w_h_next = r_h + 12'd1;
                    end
                end else begin
                    w_ph_next = r_ph + PH_W'(1);
                end
            end
        end
    end

    // Outputs are decoded from the next counter state so the registers line up with it.
    always_comb begin
        w_run              = (w_state_next == StRun);
        w_hs_window        = (w_h_next >= H_SYNC_LO) && (w_h_next < H_SYNC_HI);
        w_vs_window        = (w_v_next >= V_SYNC_LO) && (w_v_next < V_SYNC_HI);
        w_de_next          = w_run && (w_h_next < H_CFG.active) && (w_v_next < V_CFG.active);
        w_hsync_next       = (w_run && w_hs_window) ? HS_POL : ~HS_POL;
        w_vsync_next       = (w_run && w_vs_window) ? VS_POL : ~VS_POL;
        w_pix_ce_next      = w_run && (w_ph_next == '0);
        w_dclk_next        = w_run && (w_ph_next >= PH_HALF);
        w_frame_start_next = w_pix_ce_next && (w_h_next == '0) && (w_v_next == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StIdle;
            r_ph    <= '0;
            r_h     <= '0;
            r_v     <= '0;
        end else begin
            r_state <= w_state_next;
            r_ph    <= w_ph_next;
            r_h     <= w_h_next;
            r_v     <= w_v_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dclk        <= 1'b0;
            r_pix_ce      <= 1'b0;
            r_hsync       <= ~HS_POL;
            r_vsync       <= ~VS_POL;
            r_de          <= 1'b0;
            r_frame_start <= 1'b0;
            r_x           <= '0;
            r_y           <= '0;
        end else begin
            r_dclk        <= w_dclk_next;
            r_pix_ce      <= w_pix_ce_next;
            r_hsync       <= w_hsync_next;
            r_vsync       <= w_vsync_next;
            r_de          <= w_de_next;
            r_frame_start <= w_frame_start_next;
            r_x           <= w_h_next;
            r_y           <= w_v_next;
        end
    end

    assign lcd_dclk    = r_dclk;
    assign pix_ce      = r_pix_ce;
    assign hsync       = r_hsync;
    assign vsync       = r_vsync;
    assign de          = r_de;
    assign frame_start = r_frame_start;
    assign x           = r_x;
    assign y           = r_y;

endmodule

// File: tb/tb_lcd_timing_gen.sv
// Directed bench for lcd_timing_gen: a small 7x6 frame at divide-by-2 with low syncs,
// and the same frame at divide-by-4 with high syncs, sharing clock, reset and enable.
module tb_lcd_timing_gen;

    logic clk = 1'b0;
    logic rst_n;
    logic en;

    always #5 clk = ~clk;

    logic        a_dclk, a_pce, a_hs, a_vs, a_de, a_fs;
    logic [11:0] a_x, a_y;
    logic        b_dclk, b_pce, b_hs, b_vs, b_de, b_fs;
    logic [11:0] b_x, b_y;

    lcd_timing_gen #(
        .PCLK_DIV(2), .H_ACTIVE(4), .H_FP(1), .H_SYNC(1), .H_BP(1),
        .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1), .HS_POL(1'b0), .VS_POL(1'b0)
    ) dut_a (
        .clk(clk), .rst_n(rst_n), .en(en), .lcd_dclk(a_dclk), .pix_ce(a_pce),
        .hsync(a_hs), .vsync(a_vs), .de(a_de), .x(a_x), .y(a_y), .frame_start(a_fs)
    );

    lcd_timing_gen #(
        .PCLK_DIV(4), .H_ACTIVE(4), .H_FP(1), .H_SYNC(1), .H_BP(1),
        .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1), .HS_POL(1'b1), .VS_POL(1'b1)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .en(en), .lcd_dclk(b_dclk), .pix_ce(b_pce),
        .hsync(b_hs), .vsync(b_vs), .de(b_de), .x(b_x), .y(b_y), .frame_start(b_fs)
    );

    logic [31:0] a_vec, b_vec, b_sig;
    assign a_vec = {2'b00, a_de, a_pce, a_dclk, a_hs, a_vs, a_fs, a_x, a_y};
    assign b_vec = {2'b00, b_de, b_pce, b_dclk, b_hs, b_vs, b_fs, b_x, b_y};
    assign b_sig = {28'd0, b_pce, b_dclk, b_hs, b_vs};

    int checks   = 0;
    int failures = 0;

    typedef struct {
        int          k;
        logic [31:0] exp;
    } vec_t;

    vec_t a_tab[$];
    vec_t b_tab[$];

    function automatic logic [31:0] mk(input logic de, input logic pce, input logic dclk,
                                       input logic hs, input logic vs, input logic fs,
                                       input int xx, input int yy);
        return {2'b00, de, pce, dclk, hs, vs, fs, 12'(xx), 12'(yy)};
    endfunction

    function automatic logic [31:0] mkb(input logic pce, input logic dclk, input logic hs,
                                        input logic vs);
        return {28'd0, pce, dclk, hs, vs};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int k, bi;
        int de_cnt, hs_lo, vs_lo, fs_cnt, b_hs_hi, b_vs_hi, viol;
        logic [11:0] px, py;
        logic pde, phs, pvs;

        // A: (k, de pce dclk hs vs fs x y); k counts edges since en rose
        a_tab.push_back('{1,   mk(1, 1, 0, 1, 1, 1, 0, 0)});
        a_tab.push_back('{2,   mk(1, 0, 1, 1, 1, 0, 0, 0)});
        a_tab.push_back('{8,   mk(1, 0, 1, 1, 1, 0, 3, 0)});
        a_tab.push_back('{9,   mk(0, 1, 0, 1, 1, 0, 4, 0)});
        a_tab.push_back('{11,  mk(0, 1, 0, 0, 1, 0, 5, 0)});
        a_tab.push_back('{12,  mk(0, 0, 1, 0, 1, 0, 5, 0)});
        a_tab.push_back('{13,  mk(0, 1, 0, 1, 1, 0, 6, 0)});
        a_tab.push_back('{15,  mk(1, 1, 0, 1, 1, 0, 0, 1)});
        a_tab.push_back('{43,  mk(0, 1, 0, 1, 1, 0, 0, 3)});
        a_tab.push_back('{57,  mk(0, 1, 0, 1, 0, 0, 0, 4)});
        a_tab.push_back('{70,  mk(0, 0, 1, 1, 0, 0, 6, 4)});
        a_tab.push_back('{71,  mk(0, 1, 0, 1, 1, 0, 0, 5)});
        a_tab.push_back('{83,  mk(0, 1, 0, 1, 1, 0, 6, 5)});
        a_tab.push_back('{84,  mk(0, 0, 1, 1, 1, 0, 6, 5)});
        a_tab.push_back('{85,  mk(1, 1, 0, 1, 1, 1, 0, 0)});
        a_tab.push_back('{86,  mk(1, 0, 1, 1, 1, 0, 0, 0)});
        a_tab.push_back('{169, mk(1, 1, 0, 1, 1, 1, 0, 0)});
        a_tab.push_back('{170, mk(1, 0, 1, 1, 1, 0, 0, 0)});

        // B: (k, pce dclk hs vs), divide-by-4 with active-high syncs
        b_tab.push_back('{1,   mkb(1, 0, 0, 0)});
        b_tab.push_back('{2,   mkb(0, 0, 0, 0)});
        b_tab.push_back('{3,   mkb(0, 1, 0, 0)});
        b_tab.push_back('{4,   mkb(0, 1, 0, 0)});
        b_tab.push_back('{5,   mkb(1, 0, 0, 0)});
        b_tab.push_back('{20,  mkb(0, 1, 0, 0)});
        b_tab.push_back('{21,  mkb(1, 0, 1, 0)});
        b_tab.push_back('{24,  mkb(0, 1, 1, 0)});
        b_tab.push_back('{25,  mkb(1, 0, 0, 0)});
        b_tab.push_back('{112, mkb(0, 1, 0, 0)});
        b_tab.push_back('{113, mkb(1, 0, 0, 1)});
        b_tab.push_back('{140, mkb(0, 1, 0, 1)});
        b_tab.push_back('{141, mkb(1, 0, 0, 0)});

        rst_n = 1'b0;
        en    = 1'b0;
        step();
        step();
        check("reset_a", a_vec, mk(0, 0, 0, 1, 1, 0, 0, 0));
        check("reset_b", b_vec, mk(0, 0, 0, 0, 0, 0, 0, 0));
        rst_n = 1'b1;
        step();
        step();
        step();
        check("idle_en0_a", a_vec, mk(0, 0, 0, 1, 1, 0, 0, 0));
        check("idle_en0_b", b_vec, mk(0, 0, 0, 0, 0, 0, 0, 0));

        en = 1'b1;
        k = 0; bi = 0;
        de_cnt = 0; hs_lo = 0; vs_lo = 0; fs_cnt = 0; b_hs_hi = 0; b_vs_hi = 0; viol = 0;
        px = a_x; py = a_y; pde = a_de; phs = a_hs; pvs = a_vs;
        for (int i = 0; i < a_tab.size(); i++) begin
            while (k < a_tab[i].k) begin
                step();
                k++;
                if (k <= 84) begin
                    de_cnt += int'(a_de & a_pce);
                    hs_lo  += int'(!a_hs);
                    vs_lo  += int'(!a_vs);
                end
                if (k <= 168) begin
                    fs_cnt  += int'(a_fs);
                    b_hs_hi += int'(b_hs);
                    b_vs_hi += int'(b_vs);
                end
                if (!a_pce && (a_x != px || a_y != py || a_de != pde || a_hs != phs ||
                               a_vs != pvs)) begin
                    viol++;
                end
                px = a_x; py = a_y; pde = a_de; phs = a_hs; pvs = a_vs;
                if (bi < b_tab.size() && b_tab[bi].k == k) begin
                    check($sformatf("b_k%0d", k), b_sig, b_tab[bi].exp);
                    bi++;
                end
            end
            check($sformatf("a_k%0d", k), a_vec, a_tab[i].exp);
        end
        check("b_table_consumed", 32'(bi), 32'(b_tab.size()));
        check("a_de_pixels_per_frame", 32'(de_cnt), 32'd12);
        check("a_hsync_low_clks", 32'(hs_lo), 32'd12);
        check("a_vsync_low_clks", 32'(vs_lo), 32'd14);
        check("a_frame_starts_2frames", 32'(fs_cnt), 32'd2);
        check("b_hsync_high_clks", 32'(b_hs_hi), 32'd24);
        check("b_vsync_high_clks", 32'(b_vs_hi), 32'd28);
        check("a_change_off_pix_ce", 32'(viol), 32'd0);

        // Asynchronous reset mid-frame: idle values must appear without a clock edge
        rst_n = 1'b0;
        #2;
        check("async_reset_a", a_vec, mk(0, 0, 0, 1, 1, 0, 0, 0));
        check("async_reset_b", b_vec, mk(0, 0, 0, 0, 0, 0, 0, 0));
        en = 1'b0;
        #1;
        rst_n = 1'b1;
        step();
        step();
        check("post_reset_idle_a", a_vec, mk(0, 0, 0, 1, 1, 0, 0, 0));

        // Enable drop at (2,1), then restart from (0,0)
        en = 1'b1;
        for (int i = 0; i < 19; i++) step();
        check("drop_pos_a", a_vec, mk(1, 1, 0, 1, 1, 0, 2, 1));
        en = 1'b0;
        step();
        check("drop_idle_a", a_vec, mk(0, 0, 0, 1, 1, 0, 0, 0));
        check("drop_idle_b", b_vec, mk(0, 0, 0, 0, 0, 0, 0, 0));
        en = 1'b1;
        step();
        check("restart_a", a_vec, mk(1, 1, 0, 1, 1, 1, 0, 0));
        step();
        check("restart_fs_drop_a", a_vec, mk(1, 0, 1, 1, 1, 0, 0, 0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
